simon_core_param: RTL and testbench

Parametrised iterative SIMON block cipher core covering all ten SIMON block/key sizes from one source, with a configurable number of rounds per clock. It expands the key once into a round-key register file and then encrypts or decrypts blocks on request. It is the drop-in successor to the fixed-size SIMON top levels and sits between the host load/read handshake and any mode-of-operation wrapper.

---
 rtl/simon_core_param_if.sv | 28 ++
 rtl/simon_core_param.sv | 223 ++++++++++++++++++++++
 tb/tb_simon_core_param.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_core_param_if.sv
// Host-side handshake bundle for simon_core_param: key/data load requests, result read-back.
// N is the word size and M the number of key words; both must match the core's parameters.
interface simon_core_param_if #(
  parameter int N = 64,
  parameter int M = 4
);
  logic                  newKey;
  logic [M-1:0][N-1:0]   KEY;
  logic                  newData;
  logic                  enc_dec;
  logic [1:0][N-1:0]     BLOCK;
  logic                  readData;
  logic                  loadKey;
  logic                  loadData;
  logic                  doneKey;
  logic                  doneData;
  logic [1:0][N-1:0]     outData;

  modport master (
    output newKey, KEY, newData, enc_dec, BLOCK, readData,
    input  loadKey, loadData, doneKey, doneData, outData
  );

  modport slave (
    input  newKey, KEY, newData, enc_dec, BLOCK, readData,
    output loadKey, loadData, doneKey, doneData, outData
  );
endinterface

// File: rtl/simon_core_param.sv
// Iterative SIMON 2N/MN core: one-shot key expansion into a round-key file, then U rounds per clock.
// Macro SIMON_DEC_EN builds the decrypt datapath; without it every block is encrypted.
module simon_core_param #(
  parameter int N    = 64,
  parameter int M    = 4,
  parameter int T    = 72,
  parameter int ZSEL = 4,
  parameter int U    = 1
) (
  input logic               clk,
  input logic               R,
  simon_core_param_if.slave bus
);

  localparam int UU = (U < 1) ? 1 : U;
  localparam int CW = $clog2(T);
  localparam int NR = T / UU;

  localparam bit LEGAL =
      (N == 16 && M == 4 && T == 32 && ZSEL == 0) ||
      (N == 24 && M == 3 && T == 36 && ZSEL == 0) ||
      (N == 24 && M == 4 && T == 36 && ZSEL == 1) ||
      (N == 32 && M == 3 && T == 42 && ZSEL == 2) ||
      (N == 32 && M == 4 && T == 44 && ZSEL == 3) ||
      (N == 48 && M == 2 && T == 52 && ZSEL == 2) ||
      (N == 48 && M == 3 && T == 54 && ZSEL == 3) ||
      (N == 64 && M == 2 && T == 68 && ZSEL == 2) ||
      (N == 64 && M == 3 && T == 69 && ZSEL == 3) ||
      (N == 64 && M == 4 && T == 72 && ZSEL == 4);

  if (!LEGAL || (U < 1) || ((T % UU) != 0)) begin : g_bad_cfg
    $error("simon_core_param: unsupported N=%0d M=%0d T=%0d ZSEL=%0d U=%0d", N, M, T, ZSEL, U);
  end

  // Bit i of each constant is z_j[i], i.e. the sequence is consumed LSB first.
  function automatic logic [61:0] z_seq(input int sel);
    case (sel)
      0:       return 62'h19C3522FB386A45F;
      1:       return 62'h16864FB8AD0C9F71;
      2:       return 62'h3369F885192C0EF5;
      3:       return 62'h3C2CE51207A635DB;
      4:       return 62'h3DC94C3A046D678B;
      default: return '0;
    endcase
  endfunction

  localparam logic [61:0] ZSEQ = z_seq(ZSEL);

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] simon_f(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  typedef enum logic [2:0] {IDLE, KEXP, READY, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            load_key_reg, load_key_next;
  logic            load_data_reg, load_data_next;
  logic            done_key_reg, done_key_next;
  logic            done_data_reg, done_data_next;

  logic [N-1:0]    rk_reg [T];
  logic [N-1:0]    x_reg, y_reg;
  logic [1:0][N-1:0] out_reg;
  logic [N-1:0]    ks_tmp, ks_word;
  logic            key_acc, data_acc, last_round;

  // newKey wins over newData when both arrive in READY.
  assign key_acc    = bus.newKey && (state_reg == IDLE || state_reg == READY);
  assign data_acc   = bus.newData && !bus.newKey && (state_reg == READY);
  assign last_round = (state_reg == RUN) && (cnt_reg == CW'(NR - 1));

  always_ff @(posedge clk) begin
    if (R) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      load_key_reg  <= 1'b0;
      load_data_reg <= 1'b0;
      done_key_reg  <= 1'b0;
      done_data_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      load_key_reg  <= load_key_next;
      load_data_reg <= load_data_next;
      done_key_reg  <= done_key_next;
      done_data_reg <= done_data_next;
    end
  end

  // Flags are registered from the next state so they are all low while R is held.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (key_acc) begin
          state_next = KEXP;
          cnt_next   = '0;
        end
      end
      KEXP: begin
        if (cnt_reg == CW'(T - M - 1)) begin
          state_next = READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      READY: begin
        if (key_acc) begin
          state_next = KEXP;
          cnt_next   = '0;
        end else if (data_acc) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (last_round) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE: begin
        if (bus.readData) state_next = READY;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    load_key_next  = (state_next == IDLE) || (state_next == READY);
    load_data_next = (state_next == READY);
    done_key_next  = (state_next == READY) || (state_next == RUN) || (state_next == DONE);
    done_data_next = (state_next == DONE);
  end

  always_comb begin
    ks_tmp = ror(rk_reg[cnt_reg + CW'(M - 1)], 3);
    if (M == 4) ks_tmp = ks_tmp ^ rk_reg[cnt_reg + CW'(1)];
    ks_word = ~rk_reg[cnt_reg] ^ ks_tmp ^ ror(ks_tmp, 1)
              ^ N'(ZSEQ[6'(int'(cnt_reg) % 62)]) ^ N'(3);
  end

  always_ff @(posedge clk) begin
    if (R) begin
      for (int i = 0; i < T; i++) rk_reg[i] <= '0;
    end else if (key_acc) begin
      for (int i = 0; i < M; i++) rk_reg[i] <= bus.KEY[i];
    end else if (state_reg == KEXP) begin
      rk_reg[cnt_reg + CW'(M)] <= ks_word;
    end
  end

`ifdef SIMON_DEC_EN
  logic dec_reg;

  always_ff @(posedge clk) begin
    if (R)             dec_reg <= 1'b0;
    else if (data_acc) dec_reg <= bus.enc_dec;
  end
`else
  logic unused_enc_dec;
  assign unused_enc_dec = bus.enc_dec;
`endif

  logic [N-1:0] cx [UU+1];
  logic [N-1:0] cy [UU+1];

  assign cx[0] = x_reg;
  assign cy[0] = y_reg;

  // Stage gi of cycle c consumes round key U*c+gi (mirrored for decrypt).
  for (genvar gi = 0; gi < UU; gi++) begin : g_round
    logic [CW-1:0] fwd_idx;
    assign fwd_idx = CW'(int'(cnt_reg) * UU + gi);
`ifdef SIMON_DEC_EN
    logic [CW-1:0] rev_idx;
    assign rev_idx   = CW'(T - 1 - (int'(cnt_reg) * UU + gi));
    assign cx[gi+1] = dec_reg ? cy[gi] : (cy[gi] ^ simon_f(cx[gi]) ^ rk_reg[fwd_idx]);
    assign cy[gi+1] = dec_reg ? (cx[gi] ^ simon_f(cy[gi]) ^ rk_reg[rev_idx]) : cx[gi];
`else
    assign cx[gi+1] = cy[gi] ^ simon_f(cx[gi]) ^ rk_reg[fwd_idx];
    assign cy[gi+1] = cx[gi];
`endif
  end

  always_ff @(posedge clk) begin
    if (R) begin
      x_reg   <= '0;
      y_reg   <= '0;
      out_reg <= '0;
    end else if (data_acc) begin
      x_reg <= bus.BLOCK[1];
      y_reg <= bus.BLOCK[0];
    end else if (state_reg == RUN) begin
      x_reg <= cx[UU];
      y_reg <= cy[UU];
      if (last_round) begin
        out_reg[1] <= cx[UU];
        out_reg[0] <= cy[UU];
      end
    end
  end

  assign bus.loadKey  = load_key_reg;
  assign bus.loadData = load_data_reg;
  assign bus.doneKey  = done_key_reg;
  assign bus.doneData = done_data_reg;
  assign bus.outData  = out_reg;

endmodule

// File: tb/tb_simon_core_param.sv
// Scoreboard bench for simon_core_param: SIMON32/64 (U=1) and SIMON128/256 (U=4) instances
// driven with published vectors; a per-instance monitor checks every presented result.
module tb_simon_core_param;

  logic clk = 1'b0;
  logic ra;
  logic rb;
  int   checks = 0;
  int   errors = 0;

  logic [31:0]  exp_a [$];
  logic [127:0] exp_b [$];
  logic         a_prev_done = 1'b0;
  logic         b_prev_done = 1'b0;

  localparam logic [63:0]  KEY_A = 64'h1918_1110_0908_0100;
  localparam logic [31:0]  PT_A  = 32'h6565_6877;
  localparam logic [31:0]  CT_A  = 32'hc69b_e9bb;
  localparam logic [255:0] KEY_B = {64'h1f1e1d1c1b1a1918, 64'h1716151413121110,
                                    64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
  localparam logic [127:0] PT_B  = {64'h74206e69206d6f6f, 64'h6d69732061207369};
  localparam logic [127:0] CT_B  = {64'h8d2b5579afc8a3a0, 64'h3bf72a87efe7b868};

  always #5 clk = ~clk;

  simon_core_param_if #(.N(16), .M(4)) ifa ();
  simon_core_param_if #(.N(64), .M(4)) ifb ();

  simon_core_param #(.N(16), .M(4), .T(32), .ZSEL(0), .U(1)) dut_a (
    .clk (clk),
    .R   (ra),
    .bus (ifa)
  );

  simon_core_param #(.N(64), .M(4), .T(72), .ZSEL(4), .U(4)) dut_b (
    .clk (clk),
    .R   (rb),
    .bus (ifb)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  // Monitors: one scoreboard pop per rising doneData.
  always @(negedge clk) begin
    if (ifa.doneData && !a_prev_done) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_done got=1 exp=0 (no block outstanding)");
      end else begin
        check("a_outData", 128'(ifa.outData), 128'(exp_a.pop_front()));
      end
    end
    a_prev_done = ifa.doneData;
  end

  always @(negedge clk) begin
    if (ifb.doneData && !b_prev_done) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_done got=1 exp=0 (no block outstanding)");
      end else begin
        check("b_outData", ifb.outData, exp_b.pop_front());
      end
    end
    b_prev_done = ifb.doneData;
  end

  task automatic a_load_key(input logic [63:0] key);
    int n;
    @(negedge clk);
    ifa.KEY    = key;
    ifa.newKey = 1'b1;
    @(negedge clk);
    ifa.newKey = 1'b0;
    check("a_key_accept_flags", {ifa.loadKey, ifa.loadData, ifa.doneKey}, 3'b000);
    n = 0;
    while (!ifa.doneKey && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("a_key_latency", n, 28);
    check("a_ready_flags", {ifa.loadKey, ifa.loadData, ifa.doneData}, 3'b110);
  endtask

  task automatic a_send(input logic [31:0] blk, input logic dec, input logic [31:0] exp, input int hold);
    int n;
    exp_a.push_back(exp);
    @(negedge clk);
    ifa.BLOCK   = blk;
    ifa.enc_dec = dec;
    ifa.newData = 1'b1;
    @(negedge clk);
    ifa.newData = 1'b0;
    check("a_data_accept_flags", {ifa.loadKey, ifa.loadData}, 2'b00);
    n = 0;
    while (!ifa.doneData && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("a_data_latency", n, 32);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("a_hold_doneData", ifa.doneData, 1'b1);
      check("a_hold_outData", 128'(ifa.outData), 128'(exp));
    end
    ifa.readData = 1'b1;
    @(negedge clk);
    ifa.readData = 1'b0;
    check("a_read_flags", {ifa.doneData, ifa.loadData}, 2'b01);
  endtask

  task automatic a_collide();
    int n;
    @(negedge clk);
    ifa.BLOCK   = PT_A;
    ifa.enc_dec = 1'b0;
    ifa.newKey  = 1'b1;
    ifa.newData = 1'b1;
    @(negedge clk);
    ifa.newKey  = 1'b0;
    ifa.newData = 1'b0;
    check("a_collide_flags", {ifa.loadKey, ifa.loadData, ifa.doneKey, ifa.doneData}, 4'b0000);
    n = 0;
    while (!ifa.doneKey && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("a_collide_latency", n, 28);
    check("a_collide_ready", {ifa.loadKey, ifa.loadData, ifa.doneData}, 3'b110);
  endtask

  task automatic a_abort();
    @(negedge clk);
    ifa.BLOCK   = PT_A;
    ifa.enc_dec = 1'b0;
    ifa.newData = 1'b1;
    @(negedge clk);
    ifa.newData = 1'b0;
    repeat (9) @(negedge clk);
    check("a_abort_running", {ifa.loadKey, ifa.loadData, ifa.doneKey, ifa.doneData}, 4'b0010);
    ra = 1'b1;
    @(negedge clk);
    check("a_abort_flags", {ifa.loadKey, ifa.loadData, ifa.doneKey, ifa.doneData}, 4'b0000);
    check("a_abort_outData", 128'(ifa.outData), 128'd0);
    ra = 1'b0;
    @(negedge clk);
    check("a_abort_idle", {ifa.loadKey, ifa.loadData, ifa.doneKey, ifa.doneData}, 4'b1000);
    repeat (40) @(negedge clk);
    check("a_abort_no_done", ifa.doneData, 1'b0);
  endtask

  task automatic b_load_key(input logic [255:0] key);
    int n;
    @(negedge clk);
    ifb.KEY    = key;
    ifb.newKey = 1'b1;
    @(negedge clk);
    ifb.newKey = 1'b0;
    n = 0;
    while (!ifb.doneKey && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("b_key_latency", n, 68);
  endtask

  task automatic b_send(input logic [127:0] blk, input logic dec, input logic [127:0] exp);
    int n;
    exp_b.push_back(exp);
    @(negedge clk);
    ifb.BLOCK   = blk;
    ifb.enc_dec = dec;
    ifb.newData = 1'b1;
    @(negedge clk);
    ifb.newData = 1'b0;
    n = 0;
    while (!ifb.doneData && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_data_latency", n, 18);
    ifb.readData = 1'b1;
    @(negedge clk);
    ifb.readData = 1'b0;
    check("b_read_flags", {ifb.doneData, ifb.loadData}, 2'b01);
  endtask

  initial begin
    ra = 1'b1;
    rb = 1'b1;
    ifa.newKey = 1'b0; ifa.KEY = '0; ifa.newData = 1'b0; ifa.enc_dec = 1'b0;
    ifa.BLOCK = '0; ifa.readData = 1'b0;
    ifb.newKey = 1'b0; ifb.KEY = '0; ifb.newData = 1'b0; ifb.enc_dec = 1'b0;
    ifb.BLOCK = '0; ifb.readData = 1'b0;
    repeat (3) @(negedge clk);
    check("a_rst_flags", {ifa.loadKey, ifa.loadData, ifa.doneKey, ifa.doneData}, 4'b0000);
    check("a_rst_outData", 128'(ifa.outData), 128'd0);
    check("b_rst_flags", {ifb.loadKey, ifb.loadData, ifb.doneKey, ifb.doneData}, 4'b0000);
    ra = 1'b0;
    rb = 1'b0;
    @(negedge clk);
    check("a_idle_flags", {ifa.loadKey, ifa.loadData, ifa.doneKey, ifa.doneData}, 4'b1000);
    check("b_idle_flags", {ifb.loadKey, ifb.loadData, ifb.doneKey, ifb.doneData}, 4'b1000);

    a_load_key(KEY_A);
    a_send(PT_A, 1'b0, CT_A, 10);
`ifdef SIMON_DEC_EN
    a_send(CT_A, 1'b1, PT_A, 0);
`else
    a_send(PT_A, 1'b1, CT_A, 0);
`endif
    a_collide();
    a_send(PT_A, 1'b0, CT_A, 0);
    a_abort();

    b_load_key(KEY_B);
    b_send(PT_B, 1'b0, CT_B);
`ifdef SIMON_DEC_EN
    b_send(CT_B, 1'b1, PT_B);
`else
    b_send(PT_B, 1'b1, CT_B);
`endif

    repeat (5) @(negedge clk);
    check("a_scoreboard_drained", exp_a.size(), 0);
    check("b_scoreboard_drained", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
